temp_flag_gen: RTL and testbench
================================

// Module: temp_flag_gen
// PURPOSE
//   Upstream conditioning stage for the room climate controller. Takes raw signed
//   temperature samples from the sensor interface and block-averages them. Compares
//   each average against the six comparison points 27/23/23/22/18/15 degC and debounces
//   every comparison result. Drives the registered threshold flags Tgt27, Tgt23, Tlt23,
//   Tlt22, Tgt18 and Tlt15 consumed by the fan/heater/AC control logic.
// PARAMETERS
//   AVG_LOG2  2   log2 of the number of valid samples per average block (block = 4)
//   DEBOUNCE  3   number of consecutive disagreeing averages needed to flip a flag (>=1)
//   TW        8   temperature sample width, two's complement, 1 LSB = 1 degC
// PORTS
//   clk          in   1   single system clock, all logic on the rising edge
//   rst          in   1   synchronous reset, active-high
//   temp_valid   in   1   temp_code is valid this cycle; no backpressure, may be high every cycle
//   temp_code    in   TW  signed sample; 8'h80 (-128) is the sensor-fault code
//   Tgt27        out  1   debounced avg > 27
//   Tgt23        out  1   debounced avg > 23
//   Tlt23        out  1   debounced avg < 23
//   Tlt22        out  1   debounced avg < 22
//   Tgt18        out  1   debounced avg > 18
//   Tlt15        out  1   debounced avg < 15
//   flags_valid  out  1   sticky; set once the first average has loaded the flags
//   avg_upd      out  1   1-cycle pulse on the cycle flag registers were evaluated
// BEHAVIOUR
//   Reset
//   - On rst=1 at a clock edge: all six flags=0, flags_valid=0, avg_upd=0.
//   - Also cleared: accumulator, sample counter, debounce counters. State <= WARMUP.
//   - rst overrides every other input. A partial average block in progress is discarded.
//   Accumulation
//   - Sample accepted when temp_valid=1 && temp_code!=8'h80.
//   - Fault samples are dropped: not summed, not counted.
//   - acc is signed, TW+AVG_LOG2 bits wide, so it cannot overflow.
//   - The sample counter wraps after 2^AVG_LOG2 accepted samples.
//   - At edge E, where the block's last sample is accepted:
//     avg_reg <= (acc + sample) >>> AVG_LOG2 (arithmetic shift, floor toward -inf);
//     acc <= 0; avg_new <= 1.
//   Evaluation (edge E+1)
//   - raw flags are computed combinationally from avg_reg with signed compares.
//   - avg_upd is high during the cycle after E+1.
//   - Flag latency: flags change at E+1, one cycle after the final sample edge.
//   FSM WARMUP -> RUN
//   - WARMUP: at the first evaluation, flags <= raw (no debounce), flags_valid <= 1,
//     state <= RUN.
//   - RUN, per flag i, at each evaluation:
//     - raw_i == flag_i: cnt_i <= 0.
//     - else if cnt_i == DEBOUNCE-1: flag_i <= raw_i, cnt_i <= 0.
//     - else: cnt_i <= cnt_i + 1.
//   - DEBOUNCE=1 means the flag follows raw at every evaluation.
//   - A single agreeing average resets a flag's disagreement count.
//   - Flags hold their value between evaluations.
//   Input boundary cases
//   - A sample accepted on the edge where avg_reg is evaluated starts the next block
//     normally; there are no dead cycles.
//   - Fault codes interleaved in a block only delay its completion.
// STRUCTURE
//   room_pkg (shared)
//   - localparams for the threshold constants T27/T23/T22/T18/T15.
//   - flag index localparams FLG_GT27..FLG_LT15 for a 6-bit flag vector.
//   - TEMP_FAULT = 8'h80.
//   flag_debounce (sub-module)
//   - Ports: clk, rst, eval, load, raw, flag; parameter DEBOUNCE.
//   - Instantiated 6x with generate.
//   Top level: accumulator, sample counter, average register, WARMUP/RUN FSM.
// TESTING  (AVG_LOG2=2, DEBOUNCE=3)
//   1 rst, then four samples 25 -> at E+1: Tgt23=1, Tgt18=1, others 0,
//     flags_valid=1, one avg_upd pulse.
//   2 From state 1, three blocks of 28 -> Tgt27 stays 0 after blocks 1 and 2 and is 1
//     after block 3. Block 28,20(avg 22),28 inserted midway -> debounce restarts.
//   3 Samples 27,27,27,28 (sum 109) -> avg 27, Tgt27=0.
//     Samples -3,-2,-2,-2 (sum -9) -> avg -3 in WARMUP, Tlt15=Tlt22=Tlt23=1.
//   4 Samples 20,8'h80,20,8'h80,20,20 -> one average of 20 only after the 4th valid
//     20; fault samples are not counted.
//   5 Three samples 30, assert rst one cycle, then four samples 20 -> avg 20,
//     flags_valid reasserts only after those four, Tgt18=1, Tlt22=Tlt23=1.
//   6 temp_valid held high for 16 cycles of 30 -> avg_upd pulses every 4 cycles.
//     Tgt27 set at the first evaluation (WARMUP load); no sample is dropped.

Source files
------------

// File: rtl/room_pkg.sv
// Shared constants for the room climate controller: comparison points, flag
// vector layout, sensor fault code and conditioning FSM states.
package room_pkg;

    localparam int T27 = 27;
    localparam int T23 = 23;
    localparam int T22 = 22;
    localparam int T18 = 18;
    localparam int T15 = 15;

    localparam int unsigned NUM_FLAGS = 6;
    localparam int unsigned FLG_GT27  = 0;
    localparam int unsigned FLG_GT23  = 1;
    localparam int unsigned FLG_LT23  = 2;
    localparam int unsigned FLG_LT22  = 3;
    localparam int unsigned FLG_GT18  = 4;
    localparam int unsigned FLG_LT15  = 5;

    localparam logic [7:0] TEMP_FAULT = 8'h80;

    typedef enum logic {
        StWarmup,
        StRun
    } state_e;

endpackage

// File: rtl/flag_debounce.sv
// One debounced threshold flag: flips only after DEBOUNCE consecutive
// disagreeing evaluations; load takes the raw value directly.
module flag_debounce #(
    parameter int unsigned DEBOUNCE = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic eval,
    input  logic load,
    input  logic raw,
    output logic flag
);

    localparam int unsigned CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE - 1);

    logic          flag_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            flag_q <= 1'b0;
            cnt_q  <= '0;
        end else if (eval) begin
            if (load || (raw == flag_q) || (cnt_q == LAST)) begin
                flag_q <= raw;
                cnt_q  <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign flag = flag_q;

endmodule

// File: rtl/temp_flag_gen.sv
// Block-averages valid sensor samples and drives six debounced threshold flags
// for the fan/heater/AC control logic.
module temp_flag_gen
    import room_pkg::*;
#(
    parameter int unsigned AVG_LOG2 = 2,
    parameter int unsigned DEBOUNCE = 3,
    parameter int unsigned TW       = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 temp_valid,
    input  logic signed [TW-1:0] temp_code,
    output logic                 Tgt27,
    output logic                 Tgt23,
    output logic                 Tlt23,
    output logic                 Tlt22,
    output logic                 Tgt18,
    output logic                 Tlt15,
    output logic                 flags_valid,
    output logic                 avg_upd
);

    localparam int unsigned AW = TW + AVG_LOG2;

    localparam logic signed [TW-1:0] L27 = TW'(T27);
    localparam logic signed [TW-1:0] L23 = TW'(T23);
    localparam logic signed [TW-1:0] L22 = TW'(T22);
    localparam logic signed [TW-1:0] L18 = TW'(T18);
    localparam logic signed [TW-1:0] L15 = TW'(T15);

    logic signed [AW-1:0]   acc_q, acc_d, sum, shifted;
    logic [AVG_LOG2-1:0]    cnt_q, cnt_d;
    logic signed [TW-1:0]   avg_q, avg_d;
    logic                   avg_new_q, avg_new_d;
    logic                   avg_upd_q;
    logic                   flags_valid_q, flags_valid_d;
    logic                   accept, last, load;
    state_e                 state_q, state_d;
    logic [NUM_FLAGS-1:0]   raw, flags;

    assign accept  = temp_valid && (temp_code != TW'(TEMP_FAULT));
    assign last    = (cnt_q == {AVG_LOG2{1'b1}});
    assign sum     = acc_q + AW'(temp_code);
    assign shifted = sum >>> AVG_LOG2;

    always_comb begin
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        avg_d     = avg_q;
        avg_new_d = 1'b0;
        if (accept) begin
            cnt_d = cnt_q + 1'b1;
            if (last) begin
                acc_d     = '0;
                avg_d     = shifted[TW-1:0];
                avg_new_d = 1'b1;
            end else begin
                acc_d = sum;
            end
        end
    end

    // First evaluation after reset loads the flags without debouncing.
    always_comb begin
        state_d       = state_q;
        flags_valid_d = flags_valid_q;
        load          = 1'b0;
        if (avg_new_q) begin
            unique case (state_q)
                StWarmup: begin
                    load          = 1'b1;
                    flags_valid_d = 1'b1;
                    state_d       = StRun;
                end
                StRun: ;
                default: state_d = StWarmup;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q         <= '0;
            cnt_q         <= '0;
            avg_q         <= '0;
            avg_new_q     <= 1'b0;
            avg_upd_q     <= 1'b0;
            flags_valid_q <= 1'b0;
            state_q       <= StWarmup;
        end else begin
            acc_q         <= acc_d;
            cnt_q         <= cnt_d;
            avg_q         <= avg_d;
            avg_new_q     <= avg_new_d;
            avg_upd_q     <= avg_new_q;
            flags_valid_q <= flags_valid_d;
            state_q       <= state_d;
        end
    end

    always_comb begin
        raw           = '0;
        raw[FLG_GT27] = avg_q > L27;
        raw[FLG_GT23] = avg_q > L23;
        raw[FLG_LT23] = avg_q < L23;
        raw[FLG_LT22] = avg_q < L22;
        raw[FLG_GT18] = avg_q > L18;
        raw[FLG_LT15] = avg_q < L15;
    end

    for (genvar i = 0; i < NUM_FLAGS; i++) begin : g_flag
        flag_debounce #(
            .DEBOUNCE(DEBOUNCE)
        ) u_debounce (
            .clk (clk),
            .rst (rst),
            .eval(avg_new_q),
            .load(load),
            .raw (raw[i]),
            .flag(flags[i])
        );
    end

    assign Tgt27       = flags[FLG_GT27];
    assign Tgt23       = flags[FLG_GT23];
    assign Tlt23       = flags[FLG_LT23];
    assign Tlt22       = flags[FLG_LT22];
    assign Tgt18       = flags[FLG_GT18];
    assign Tlt15       = flags[FLG_LT15];
    assign flags_valid = flags_valid_q;
    assign avg_upd     = avg_upd_q;

endmodule

// File: tb/tb_temp_flag_gen.sv
// Directed self-checking bench for temp_flag_gen (AVG_LOG2=2, DEBOUNCE=3).
module tb_temp_flag_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       temp_valid = 1'b0;
    logic [7:0] temp_code = 8'd0;
    logic       Tgt27, Tgt23, Tlt23, Tlt22, Tgt18, Tlt15, flags_valid, avg_upd;
    logic [5:0] flags;

    int checks = 0;
    int errors = 0;

    // Flag vector order {Tlt15,Tgt18,Tlt22,Tlt23,Tgt23,Tgt27}
    localparam logic [5:0] F25 = 6'b010010;
    localparam logic [5:0] F28 = 6'b010011;
    localparam logic [5:0] F27 = 6'b010010;
    localparam logic [5:0] FM3 = 6'b101100;
    localparam logic [5:0] F20 = 6'b011100;

    assign flags = {Tlt15, Tgt18, Tlt22, Tlt23, Tgt23, Tgt27};

    temp_flag_gen #(
        .AVG_LOG2(2),
        .DEBOUNCE(3),
        .TW      (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .temp_valid (temp_valid),
        .temp_code  (temp_code),
        .Tgt27      (Tgt27),
        .Tgt23      (Tgt23),
        .Tlt23      (Tlt23),
        .Tlt22      (Tlt22),
        .Tgt18      (Tgt18),
        .Tlt15      (Tlt15),
        .flags_valid(flags_valid),
        .avg_upd    (avg_upd)
    );

    always #5 clk = ~clk;

    task automatic cyc(input logic v, input logic [7:0] c);
        temp_valid = v;
        temp_code  = c;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(1'b0, 8'd0);
        rst = 1'b0;
    endtask

    // Four samples of one value, then one idle cycle covering the evaluation edge.
    task automatic block(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [7:0] d);
        cyc(1'b1, a);
        cyc(1'b1, b);
        cyc(1'b1, c);
        cyc(1'b1, d);
        cyc(1'b0, 8'd0);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (flags !== 6'b0) begin
            $display("FAIL reset_flags: got %b expected %b", flags, 6'b0); errors++;
        end
        checks++;
        if ({flags_valid, avg_upd} !== 2'b00) begin
            $display("FAIL reset_valid_upd: got %b expected 00", {flags_valid, avg_upd}); errors++;
        end
    endtask

    task automatic test_first_avg();
        cyc(1'b1, 8'd25);
        cyc(1'b1, 8'd25);
        cyc(1'b1, 8'd25);
        cyc(1'b1, 8'd25);
        checks++;
        if ({flags_valid, avg_upd, flags} !== 8'b0) begin
            $display("FAIL first_before_eval: got %b expected %b",
                     {flags_valid, avg_upd, flags}, 8'b0); errors++;
        end
        cyc(1'b0, 8'd0);
        checks++;
        if (flags !== F25) begin
            $display("FAIL first_flags: got %b expected %b", flags, F25); errors++;
        end
        checks++;
        if ({flags_valid, avg_upd} !== 2'b11) begin
            $display("FAIL first_valid_upd: got %b expected 11", {flags_valid, avg_upd}); errors++;
        end
        cyc(1'b0, 8'd0);
        checks++;
        if (avg_upd !== 1'b0) begin
            $display("FAIL first_upd_pulse: got %b expected 0", avg_upd); errors++;
        end
    endtask

    task automatic test_debounce();
        block(8'd28, 8'd28, 8'd28, 8'd28);
        checks++;
        if (flags !== F25) begin
            $display("FAIL deb_blk1: got %b expected %b", flags, F25); errors++;
        end
        block(8'd28, 8'd28, 8'd28, 8'd28);
        checks++;
        if (flags !== F25) begin
            $display("FAIL deb_blk2: got %b expected %b", flags, F25); errors++;
        end
        block(8'd28, 8'd20, 8'd20, 8'd20);
        checks++;
        if (flags !== F25) begin
            $display("FAIL deb_avg22: got %b expected %b", flags, F25); errors++;
        end
        block(8'd28, 8'd28, 8'd28, 8'd28);
        block(8'd28, 8'd28, 8'd28, 8'd28);
        checks++;
        if (flags !== F25) begin
            $display("FAIL deb_restart: got %b expected %b", flags, F25); errors++;
        end
        block(8'd28, 8'd28, 8'd28, 8'd28);
        checks++;
        if (flags !== F28) begin
            $display("FAIL deb_flip: got %b expected %b", flags, F28); errors++;
        end
    endtask

    task automatic test_rounding();
        do_reset();
        block(8'd27, 8'd27, 8'd27, 8'd28);
        checks++;
        if (flags !== F27) begin
            $display("FAIL avg27_flags: got %b expected %b", flags, F27); errors++;
        end
        do_reset();
        block(8'hFD, 8'hFE, 8'hFE, 8'hFE);
        checks++;
        if (flags !== FM3) begin
            $display("FAIL avg_m3_flags: got %b expected %b", flags, FM3); errors++;
        end
        checks++;
        if (flags_valid !== 1'b1) begin
            $display("FAIL avg_m3_valid: got %b expected 1", flags_valid); errors++;
        end
    endtask

    task automatic test_fault();
        do_reset();
        cyc(1'b1, 8'd20);
        cyc(1'b1, 8'h80);
        cyc(1'b1, 8'd20);
        cyc(1'b1, 8'h80);
        cyc(1'b1, 8'd20);
        cyc(1'b0, 8'd0);
        checks++;
        if ({flags_valid, avg_upd} !== 2'b00) begin
            $display("FAIL fault_early: got %b expected 00", {flags_valid, avg_upd}); errors++;
        end
        cyc(1'b1, 8'd20);
        cyc(1'b0, 8'd0);
        checks++;
        if ({flags_valid, avg_upd, flags} !== {2'b11, F20}) begin
            $display("FAIL fault_avg20: got %b expected %b",
                     {flags_valid, avg_upd, flags}, {2'b11, F20}); errors++;
        end
    endtask

    task automatic test_reset_midblock();
        do_reset();
        cyc(1'b1, 8'd30);
        cyc(1'b1, 8'd30);
        cyc(1'b1, 8'd30);
        do_reset();
        cyc(1'b1, 8'd20);
        cyc(1'b1, 8'd20);
        cyc(1'b1, 8'd20);
        cyc(1'b1, 8'd20);
        checks++;
        if (flags_valid !== 1'b0) begin
            $display("FAIL midrst_early_valid: got %b expected 0", flags_valid); errors++;
        end
        cyc(1'b0, 8'd0);
        checks++;
        if ({flags_valid, flags} !== {1'b1, F20}) begin
            $display("FAIL midrst_flags: got %b expected %b",
                     {flags_valid, flags}, {1'b1, F20}); errors++;
        end
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        logic exp_upd;
        do_reset();
        for (int k = 1; k <= 20; k++) begin
            cyc(k <= 16, 8'd30);
            exp_upd = (k > 1) && (k <= 17) && ((k % 4) == 1);
            if (avg_upd === 1'b1) pulses++;
            checks++;
            if (avg_upd !== exp_upd) begin
                $display("FAIL b2b_upd_cycle%0d: got %b expected %b", k, avg_upd, exp_upd);
                errors++;
            end
            if (k == 5) begin
                checks++;
                if (Tgt27 !== 1'b1) begin
                    $display("FAIL b2b_warmup_tgt27: got %b expected 1", Tgt27); errors++;
                end
            end
        end
        checks++;
        if (pulses != 4) begin
            $display("FAIL b2b_pulse_count: got %0d expected 4", pulses); errors++;
        end
        checks++;
        if (flags !== F28) begin
            $display("FAIL b2b_flags: got %b expected %b", flags, F28); errors++;
        end
    endtask

    initial begin
        test_reset();
        test_first_avg();
        test_debounce();
        test_rounding();
        test_fault();
        test_reset_midblock();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
